seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Four-digit time-multiplexed scan controller for the board's 7-segment display (DS_EN1..4 digit
//   enables, DS_A..DS_G/DS_DP segment lines, all active-low). Owns the shared segment bus: one digit
//   enabled per slot, with a blanking dead-time to stop ghosting. Display content is written by a
//   req/ack port and takes effect only at a frame boundary, so a frame never shows mixed values.
// PARAMETERS
//   DIGIT_CYC  12_000  CLK cycles per digit slot (250 us at 48 MHz; 1 kHz frame rate); must be >= 2
//   BLANK_CYC  480     cycles at slot start with all digits off; must be >= 1 and < DIGIT_CYC
// PORTS
//   CLK         in   1   system clock, 48 MHz
//   sys_rstn    in   1   reset: synchronous, active-low
//   wr_val      in   16  four hex nibbles; [3:0] -> digit0 (DS_EN1), [15:12] -> digit3 (DS_EN4)
//   wr_dp       in   4   decimal point per digit, 1 = lit
//   wr_blank    in   4   per-digit blank, 1 = digit never enabled
//   wr_req      in   1   write request; held high until wr_ack is seen
//   wr_ack      out  1   one-cycle pulse: write captured into staging
//   frame_tick  out  1   one-cycle pulse at the start of each frame
//   DS_EN       out  4   digit enables, active-low; DS_EN[0] = DS_EN1
//   DS_SEG      out  7   segments {G,F,E,D,C,B,A}, active-low
//   DS_DP       out  1   decimal point, active-low
// BEHAVIOUR
//   Reset (sys_rstn low at a CLK edge): cnt=0, idx=0, staging empty, shadow val=0, dp=0,
//     blank=4'b1111; DS_EN=4'b1111, DS_SEG=7'h7F, DS_DP=1, wr_ack=0, frame_tick=0. Reset during
//     any activity takes effect at that edge and discards pending staging without an ack.
//   Scan counter: cnt runs 0..DIGIT_CYC-1. At cnt==DIGIT_CYC-1: cnt->0 and idx->idx+1 (mod 4;
//     3 wraps to 0). The edge where idx 3->0 is the frame boundary.
//   Slot states: BLANK when cnt<BLANK_CYC; ON otherwise.
//     BLANK: DS_EN=1111, DS_SEG=7'h7F, DS_DP=1.
//     ON: DS_EN[idx]=0 and other enables 1, unless shadow blank[idx]=1, which forces BLANK outputs.
//       DS_SEG=~dec(val[idx]); DS_DP=~dp[idx].
//   Outputs are registered and decoded from the next-state cnt/idx, so pins change on the same edge
//     as cnt/idx. Any two digit enables are never low together.
//   Decode table, active-high {G..A}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C
//     C=39 d=5E E=79 F=71.
//   Write handshake: an edge with wr_req=1, staging empty and wr_ack=0 captures wr_val/wr_dp/
//     wr_blank into staging, sets pending, and drives wr_ack=1 for the following cycle. wr_req high
//     during the ack cycle is ignored, so a requester dropping req on ack is never double-captured.
//     While pending=1, wr_req is held off with no ack.
//   Commit: at the frame-boundary edge with pending=1, shadow<=staging and pending clears.
//     Capture is then possible at the next edge at the earliest.
//     Boundary and wr_req at the same edge with pending=1: commit only; the new request is captured
//     at the next edge and acked one cycle later.
//   frame_tick=1 in the cycle after each frame-boundary edge (cnt=0, idx=0), including after
//     commits. There is no frame_tick in the first frame after reset.
// TESTING (bench params DIGIT_CYC=8, BLANK_CYC=2; frame = 32 cycles)
//   1 Hold sys_rstn low 3 cycles -> DS_EN=1111, DS_SEG=7F, DS_DP=1, wr_ack=0. Release -> all digits
//     stay off for the whole first frame; frame_tick period is exactly 32 cycles.
//   2 Write val=16'h1234, dp=4'b0001, blank=0 -> wr_ack pulses 1 cycle. Until the next frame_tick,
//     DS_EN stays 1111. Then in slot0, cycles 0-1 DS_EN=1111; cycles 2-7 DS_EN=1110, DS_SEG=7'h19,
//     DS_DP=0. In slot3, DS_EN=0111 and DS_SEG=7'h79 (digit "1").
//   3 Issue a second write (val=16'hABCD) right after the first ack -> no ack until the edge after
//     the commit. 1234 is shown for one full frame, then ABCD for one full frame.
//   4 wr_req rises on the frame-boundary edge with pending=1 -> commit at that edge, capture next
//     edge, wr_ack one cycle after capture; exactly one ack per request.
//   5 blank=4'b1010 -> DS_EN[1] and DS_EN[3] never low; slots 1 and 3 show DS_SEG=7F, DS_DP=1.
//   6 Pulse sys_rstn low for 1 cycle while a write is pending mid-frame -> no wr_ack. After release,
//     display all off; the stale value never appears.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with blanking dead-time and a
// req/ack write port whose contents are committed to the display only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGIT_CYC = 12000,
  parameter int BLANK_CYC = 480
) (
  input  logic        CLK,
  input  logic        sys_rstn,
  input  logic [15:0] wr_val,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  input  logic        wr_req,
  output logic        wr_ack,
  output logic        frame_tick,
  output logic [3:0]  DS_EN,
  output logic [6:0]  DS_SEG,
  output logic        DS_DP
);
  localparam int CW = (DIGIT_CYC > 2) ? $clog2(DIGIT_CYC) : 1;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  localparam disp_t DISP_RST = '{val: 16'h0, dp: 4'h0, blank: 4'hF};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  disp_t         stg_q, stg_d;
  disp_t         sh_q, sh_d;
  logic          ack_q, ack_d;
  logic          tick_q, tick_d;
  logic [3:0]    en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap, bnd, on;
  logic [3:0]    nib;

  // Active-high {G..A} pattern for a hex nibble.
  function automatic logic [6:0] seg_dec(input logic [3:0] n);
    case (n)
      4'h0: seg_dec = 7'h3F;  4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;  4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;  4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;  4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;  4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;  4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;  4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;  default: seg_dec = 7'h71;
    endcase
  endfunction

  always_comb begin
    wrap   = (cnt_q == CW'(DIGIT_CYC - 1));
    bnd    = wrap && (idx_q == 2'd3);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    pend_d = pend_q;
    stg_d  = stg_q;
    sh_d   = sh_q;
    tick_d = bnd;
    ack_d  = 1'b0;

    // Commit needs pending set before this edge; capture needs it clear, so the
    // two never happen on the same edge.
    if (bnd && pend_q) begin
      sh_d   = stg_q;
      pend_d = 1'b0;
    end
    if (wr_req && !pend_q && !ack_q) begin
      stg_d  = '{val: wr_val, dp: wr_dp, blank: wr_blank};
      pend_d = 1'b1;
      ack_d  = 1'b1;
    end

    // Pins are decoded from next-state so they change together with cnt/idx.
    on    = (cnt_d >= CW'(BLANK_CYC)) && !sh_d.blank[idx_d];
    nib   = sh_d.val[{idx_d, 2'b00} +: 4];
    en_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (on) begin
      en_d[idx_d] = 1'b0;
      seg_d       = ~seg_dec(nib);
      dp_d        = ~sh_d.dp[idx_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (!sys_rstn) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      stg_q  <= DISP_RST;
      sh_q   <= DISP_RST;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
      en_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      stg_q  <= stg_d;
      sh_q   <= sh_d;
      ack_q  <= ack_d;
      tick_q <= tick_d;
      en_q   <= en_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign wr_ack     = ack_q;
  assign frame_tick = tick_q;
  assign DS_EN      = en_q;
  assign DS_SEG     = seg_q;
  assign DS_DP      = dp_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with an 8-cycle slot / 2-cycle blank: per-cycle frame model,
// write scoreboard, decode table vectors and hand-written handshake/reset sequences.
module tb_seg_scan_ctrl;
  logic        CLK = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [15:0] wr_val = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_blank = '0;
  logic        wr_req = 1'b0;
  logic        wr_ack, frame_tick, DS_DP;
  logic [3:0]  DS_EN;
  logic [6:0]  DS_SEG;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.DIGIT_CYC(8), .BLANK_CYC(2)) dut (
    .CLK(CLK), .sys_rstn(sys_rstn), .wr_val(wr_val), .wr_dp(wr_dp),
    .wr_blank(wr_blank), .wr_req(wr_req), .wr_ack(wr_ack), .frame_tick(frame_tick),
    .DS_EN(DS_EN), .DS_SEG(DS_SEG), .DS_DP(DS_DP)
  );

  typedef struct {logic [15:0] val; logic [3:0] dp; logic [3:0] blank;} wr_t;
  typedef struct {logic [3:0] nib; logic [6:0] seg;} dec_t;

  wr_t  exp_q[$];
  dec_t tbl[16];
  int   n_cmp = 0, n_bad = 0;

  // model state: t = edges since reset release
  int          t = 0, gcyc = 0, last_tick = -1, last_ack = -1, raise_cyc = 0;
  logic        m_pend = 0, m_ack = 0, m_tick = 0;
  wr_t         m_sh = '{16'h0, 4'h0, 4'hF};
  wr_t         m_stg = '{16'h0, 4'h0, 4'hF};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, gcyc);
    end
  endtask

  task automatic step();
    logic req_e, rst_e, cap, bnd, on;
    int pos, slot;
    logic [3:0] e_en, nib;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge CLK);
    req_e = wr_req;
    rst_e = sys_rstn;
    #1;
    gcyc++;
    if (!rst_e) begin
      t = 0; m_pend = 0; m_ack = 0; m_tick = 0;
      m_sh = '{16'h0, 4'h0, 4'hF};
      exp_q.delete();
    end else begin
      t++;
      bnd = (t % 32 == 0);
      cap = req_e && !m_pend && !m_ack;
      if (bnd && m_pend) begin m_sh = m_stg; m_pend = 0; end
      if (cap) m_pend = 1;
      m_ack = cap;
      m_tick = bnd;
    end
    pos  = t % 8;
    slot = (t / 8) % 4;
    on   = (pos >= 2) && !m_sh.blank[slot];
    nib  = m_sh.val[slot*4 +: 4];
    e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (on) begin e_en[slot] = 1'b0; e_seg = tbl[nib].seg; e_dp = ~m_sh.dp[slot]; end
    cmp("cycle{ack,tick,en,seg,dp}", {18'h0, wr_ack, frame_tick, DS_EN, DS_SEG, DS_DP},
        {18'h0, m_ack, m_tick, e_en, e_seg, e_dp});
    if (frame_tick) last_tick = gcyc;
    if (wr_ack) begin
      last_ack = gcyc;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_ack: got ack with no request queued (cycle %0d)", gcyc);
      end else m_stg = exp_q.pop_front();
    end
  endtask

  task automatic do_write(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                          input int align);
    bit got = 0;
    if (align >= 0) for (int k = 0; k < 64 && (t % 32) != align; k++) step();
    exp_q.push_back('{v, d, b});
    wr_val = v; wr_dp = d; wr_blank = b; wr_req = 1'b1;
    raise_cyc = gcyc;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      got = wr_ack;
    end
    wr_req = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
      exp_q.delete();
    end
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = frame_tick;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout: got no frame_tick expected one within 40 cycles");
    end
  endtask

  initial begin
    int first_tick, second_tick, lows, bad;
    tbl = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
            '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};

    // 1: reset state, dark first frame, tick period
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("reset_pins", {wr_ack, frame_tick, DS_EN, DS_SEG, DS_DP}, {2'b00, 4'hF, 7'h7F, 1'b1});
    end
    sys_rstn = 1'b1;
    first_tick = -1; second_tick = -1; lows = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (DS_EN != 4'hF) lows++;
      if (frame_tick && first_tick < 0) first_tick = k;
      else if (frame_tick && second_tick < 0) second_tick = k;
    end
    cmp("first_tick_cycle", first_tick, 32);
    cmp("tick_period", second_tick - first_tick, 32);
    cmp("dark_after_reset", lows, 0);

    // 2: single write, visible only after the next frame boundary
    do_write(16'h1234, 4'b0001, 4'b0000, 5);
    lows = 0;
    for (int k = 0; k < 40 && !frame_tick; k++) begin
      if (DS_EN != 4'hF) lows++;
      step();
    end
    cmp("dark_before_commit", lows, 0);
    cmp("tick_seen", frame_tick, 1);
    step();
    cmp("slot0_blank_en", DS_EN, 4'hF);
    step();
    cmp("slot0_on", {DS_EN, DS_SEG, DS_DP}, {4'b1110, 7'h19, 1'b0});
    while (t % 32 != 26) step();
    cmp("slot3_on", {DS_EN, DS_SEG, DS_DP}, {4'b0111, 7'h79, 1'b1});

    // 3: back-to-back writes; second held off until the commit, acked the cycle after
    do_write(16'h1234, 4'b0001, 4'b0000, -1);
    do_write(16'hABCD, 4'b0000, 4'b0000, -1);
    cmp("second_ack_after_tick", last_ack - last_tick, 1);
    step();
    cmp("frame_a_digit0", DS_SEG, 7'h19);
    wait_tick(); step(); step();
    cmp("frame_b_digit0", DS_SEG, 7'h21);

    // 4: request rising on the boundary edge while pending
    do_write(16'h1111, 4'b0000, 4'b0000, 20);
    do_write(16'h2222, 4'b0000, 4'b0000, 31);
    cmp("boundary_req_ack_lat", last_ack - raise_cyc, 2);
    for (int k = 0; k < 4; k++) step();

    // 5: per-digit blanking
    do_write(16'h8421, 4'b1111, 4'b1010, -1);
    wait_tick();
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (!DS_EN[1] || !DS_EN[3]) bad++;
      if (((t / 8) % 2 == 1) && (DS_SEG != 7'h7F || DS_DP != 1'b1)) bad++;
    end
    cmp("blanked_digits_off", bad, 0);

    // decode table: each value on all four digits, checked on slot0
    foreach (tbl[i]) begin
      do_write({4{tbl[i].nib}}, 4'b0000, 4'b0000, -1);
      wait_tick(); step(); step();
      cmp($sformatf("decode_%h", tbl[i].nib), {DS_EN, DS_SEG}, {4'b1110, tbl[i].seg});
    end

    // 6: reset pulse while a write is pending discards it
    do_write(16'h5555, 4'b1111, 4'b0000, 10);
    sys_rstn = 1'b0;
    step();
    sys_rstn = 1'b1;
    lows = 0; bad = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (DS_EN != 4'hF) lows++;
      if (wr_ack) bad++;
    end
    cmp("stale_never_shown", lows, 0);
    cmp("no_ack_after_reset", bad, 0);
    cmp("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
